// File: rtl/ahb_apb_pkg.sv
// Shared types and constants for the AHB-Lite to APB bridge.
// Optional PSLVERR error path: define AHB2APB_SLVERR_EN.
package ahb_apb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_SETUP,
        ST_ENABLE,
        ST_RESP,
        ST_ERR1,
        ST_ERR2
    } bridge_state_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int DEF_SEL_LSB = 12;
    localparam int DEF_NUM_SLV = 3;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational HADDR slave-index decode to one-hot PSEL.
// Indices at or above NUM_SLV are flagged unmapped.
module apb_addr_decoder
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int NUM_SLV = DEF_NUM_SLV,
    parameter int SEL_LSB = DEF_SEL_LSB
) (
    input  logic [ADDR_W-1:0]  haddr,
    output logic [NUM_SLV-1:0] psel,
    output logic               unmapped
);

    logic [1:0] idx;
    logic       unused_haddr;

    assign idx          = haddr[SEL_LSB+1:SEL_LSB];
    assign unused_haddr = ^haddr;

    always_comb begin
        psel     = '0;
        unmapped = 1'b1;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (idx == 2'(i)) begin
                psel[i]  = 1'b1;
                unmapped = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ahb2apb_bridge_ctrl.sv
// AHB-Lite slave to APB master bridge; all outputs registered.
// Optional PSLVERR error path: define AHB2APB_SLVERR_EN.
module ahb2apb_bridge_ctrl
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = DEF_NUM_SLV,
    parameter int SEL_LSB = DEF_SEL_LSB
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic               HSEL,
    input  logic [ADDR_W-1:0]  HADDR,
    input  logic [1:0]         HTRANS,
    input  logic               HWRITE,
    input  logic [DATA_W-1:0]  HWDATA,
    input  logic               HREADYin,
    output logic               HREADYout,
    output logic               HRESP,
    output logic [DATA_W-1:0]  HRDATA,
    output logic [ADDR_W-1:0]  PADDR,
    output logic [DATA_W-1:0]  PWDATA,
    input  logic [DATA_W-1:0]  PRDATA,
    output logic [NUM_SLV-1:0] PSEL,
    output logic               PWRITE,
    output logic               PENABLE,
    input  logic               PSLVERR
);

    bridge_state_e        state_q, state_d;
    logic                 hready_q, hready_d;
    logic                 hresp_q, hresp_d;
    logic [DATA_W-1:0]    hrdata_q, hrdata_d;
    logic [ADDR_W-1:0]    paddr_q, paddr_d;
    logic [DATA_W-1:0]    pwdata_q, pwdata_d;
    logic [NUM_SLV-1:0]   psel_q, psel_d;
    logic [NUM_SLV-1:0]   sel_q, sel_d;
    logic                 pwrite_q, pwrite_d;
    logic                 penable_q, penable_d;

    logic [NUM_SLV-1:0]   dec_sel;
    logic                 dec_unmapped;
    logic                 valid;
    logic                 slverr;
    htrans_e              htrans;

    apb_addr_decoder #(
        .ADDR_W  (ADDR_W),
        .NUM_SLV (NUM_SLV),
        .SEL_LSB (SEL_LSB)
    ) u_dec (
        .haddr    (HADDR),
        .psel     (dec_sel),
        .unmapped (dec_unmapped)
    );

`ifdef AHB2APB_SLVERR_EN
    assign slverr = PSLVERR;
`else
    logic unused_pslverr;
    assign unused_pslverr = PSLVERR;
    assign slverr         = 1'b0;
`endif

    assign htrans = htrans_e'(HTRANS);
    assign valid  = HSEL && HREADYin &&
                    (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);

    always_comb begin
        state_d   = state_q;
        hready_d  = hready_q;
        hresp_d   = hresp_q;
        hrdata_d  = hrdata_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        psel_d    = psel_q;
        sel_d     = sel_q;
        pwrite_d  = pwrite_q;
        penable_d = penable_q;
        unique case (state_q)
            ST_IDLE, ST_RESP, ST_ERR2: begin
                psel_d    = '0;
                penable_d = 1'b0;
                if (!valid) begin
                    state_d  = ST_IDLE;
                    hready_d = 1'b1;
                    hresp_d  = HRESP_OKAY;
                end else if (dec_unmapped) begin
                    // Unmapped target never touches the APB bus
                    state_d  = ST_ERR1;
                    hready_d = 1'b0;
                    hresp_d  = HRESP_ERROR;
                end else begin
                    paddr_d  = HADDR;
                    pwrite_d = HWRITE;
                    sel_d    = dec_sel;
                    hready_d = 1'b0;
                    hresp_d  = HRESP_OKAY;
                    if (HWRITE) begin
                        state_d = ST_WDATA;
                    end else begin
                        state_d = ST_SETUP;
                        psel_d  = dec_sel;
                    end
                end
            end
            ST_WDATA: begin
                pwdata_d = HWDATA;
                psel_d   = sel_q;
                state_d  = ST_SETUP;
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ENABLE;
            end
            ST_ENABLE: begin
                psel_d    = '0;
                penable_d = 1'b0;
                if (!pwrite_q) hrdata_d = PRDATA;
                if (slverr) begin
                    state_d  = ST_ERR1;
                    hready_d = 1'b0;
                    hresp_d  = HRESP_ERROR;
                end else begin
                    state_d  = ST_RESP;
                    hready_d = 1'b1;
                    hresp_d  = HRESP_OKAY;
                end
            end
            ST_ERR1: begin
                state_d  = ST_ERR2;
                hready_d = 1'b1;
                hresp_d  = HRESP_ERROR;
            end
            default: begin
                state_d  = ST_IDLE;
                hready_d = 1'b1;
                hresp_d  = HRESP_OKAY;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q   <= ST_IDLE;
            hready_q  <= 1'b1;
            hresp_q   <= HRESP_OKAY;
            hrdata_q  <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            psel_q    <= '0;
            sel_q     <= '0;
            pwrite_q  <= 1'b0;
            penable_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hready_q  <= hready_d;
            hresp_q   <= hresp_d;
            hrdata_q  <= hrdata_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            psel_q    <= psel_d;
            sel_q     <= sel_d;
            pwrite_q  <= pwrite_d;
            penable_q <= penable_d;
        end
    end

    assign HREADYout = hready_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = hrdata_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PSEL      = psel_q;
    assign PWRITE    = pwrite_q;
    assign PENABLE   = penable_q;

endmodule

// File: tb/tb_ahb2apb_bridge_ctrl.sv
// Directed-vector bench for ahb2apb_bridge_ctrl.
// Expectations follow AHB2APB_SLVERR_EN when defined.
module tb_ahb2apb_bridge_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        hreadyin;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic [2:0]  psel;
    logic        pwrite;
    logic        penable;
    logic        pslverr;

    int n_vec = 0;
    int n_bad = 0;

    ahb2apb_bridge_ctrl dut (
        .HCLK      (clk),
        .HRESETn   (rst_n),
        .HSEL      (hsel),
        .HADDR     (haddr),
        .HTRANS    (htrans),
        .HWRITE    (hwrite),
        .HWDATA    (hwdata),
        .HREADYin  (hreadyin),
        .HREADYout (hreadyout),
        .HRESP     (hresp),
        .HRDATA    (hrdata),
        .PADDR     (paddr),
        .PWDATA    (pwdata),
        .PRDATA    (prdata),
        .PSEL      (psel),
        .PWRITE    (pwrite),
        .PENABLE   (penable),
        .PSLVERR   (pslverr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic w);
        hsel   = 1'b1;
        haddr  = a;
        htrans = 2'b10;
        hwrite = w;
    endtask

    task automatic idle_bus();
        htrans = 2'b00;
        hwrite = 1'b0;
    endtask

    // bundle of APB/AHB handshake outputs: {hready, hresp, penable, psel}
    function automatic logic [31:0] bus();
        return {26'd0, hreadyout, hresp, penable, psel};
    endfunction

    initial begin
        rst_n    = 1'b0;
        hsel     = 1'b0;
        haddr    = '0;
        htrans   = 2'b00;
        hwrite   = 1'b0;
        hwdata   = '0;
        hreadyin = 1'b1;
        prdata   = '0;
        pslverr  = 1'b0;
        tick();
        tick();
        chk("rst_bus", bus(), {26'd0, 6'b10_0_000});
        chk("rst_hrdata", hrdata, 32'h0);
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_pwdata", pwdata, 32'h0);
        chk("rst_pwrite", 32'(pwrite), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("idle_bus", bus(), {26'd0, 6'b10_0_000});

        // read 0x1004
        addr_phase(32'h0000_1004, 1'b0);
        prdata = 32'hDEAD_BEEF;
        tick();
        idle_bus();
        chk("rd_setup", bus(), {26'd0, 6'b00_0_010});
        chk("rd_paddr", paddr, 32'h0000_1004);
        chk("rd_pwrite", 32'(pwrite), 32'h0);
        tick();
        chk("rd_enable", bus(), {26'd0, 6'b00_1_010});
        tick();
        chk("rd_resp", bus(), {26'd0, 6'b10_0_000});
        chk("rd_hrdata", hrdata, 32'hDEAD_BEEF);
        prdata = 32'h0;
        tick();

        // write 0x2008
        addr_phase(32'h0000_2008, 1'b1);
        tick();
        idle_bus();
        hwdata = 32'h1234_5678;
        chk("wr_wdata", bus(), {26'd0, 6'b00_0_000});
        tick();
        hwdata = 32'hFFFF_FFFF;
        chk("wr_setup", bus(), {26'd0, 6'b00_0_100});
        chk("wr_setup_pwdata", pwdata, 32'h1234_5678);
        chk("wr_setup_pwrite", 32'(pwrite), 32'h1);
        chk("wr_setup_paddr", paddr, 32'h0000_2008);
        tick();
        chk("wr_enable", bus(), {26'd0, 6'b00_1_100});
        chk("wr_enable_pwdata", pwdata, 32'h1234_5678);
        chk("wr_enable_paddr", paddr, 32'h0000_2008);
        tick();
        chk("wr_resp", bus(), {26'd0, 6'b10_0_000});
        chk("wr_hrdata_kept", hrdata, 32'hDEAD_BEEF);
        tick();

        // unmapped 0x3000, master cancels during ERR1
        addr_phase(32'h0000_3000, 1'b0);
        tick();
        idle_bus();
        chk("um_err1", bus(), {26'd0, 6'b01_0_000});
        tick();
        chk("um_err2", bus(), {26'd0, 6'b11_0_000});
        tick();
        chk("um_idle", bus(), {26'd0, 6'b10_0_000});

        // read 0x0 with PSLVERR in ENABLE
        addr_phase(32'h0000_0000, 1'b0);
        prdata = 32'hCAFE_0001;
        tick();
        idle_bus();
        chk("se_setup", bus(), {26'd0, 6'b00_0_001});
        tick();
        pslverr = 1'b1;
        chk("se_enable", bus(), {26'd0, 6'b00_1_001});
        tick();
        pslverr = 1'b0;
`ifdef AHB2APB_SLVERR_EN
        chk("se_err1", bus(), {26'd0, 6'b01_0_000});
        tick();
        chk("se_err2", bus(), {26'd0, 6'b11_0_000});
`else
        chk("se_resp", bus(), {26'd0, 6'b10_0_000});
`endif
        tick();
        chk("se_idle", bus(), {26'd0, 6'b10_0_000});

        // back-to-back write 0x10 then read 0x1010
        addr_phase(32'h0000_0010, 1'b1);
        tick();
        idle_bus();
        hwdata = 32'hA5A5_0001;
        tick();
        chk("bb_wsetup", bus(), {26'd0, 6'b00_0_001});
        chk("bb_wpwdata", pwdata, 32'hA5A5_0001);
        tick();
        chk("bb_wenable", bus(), {26'd0, 6'b00_1_001});
        tick();
        chk("bb_wresp", bus(), {26'd0, 6'b10_0_000});
        addr_phase(32'h0000_1010, 1'b0);
        prdata = 32'h0BAD_F00D;
        tick();
        idle_bus();
        chk("bb_rsetup", bus(), {26'd0, 6'b00_0_010});
        chk("bb_rpaddr", paddr, 32'h0000_1010);
        chk("bb_rpwrite", 32'(pwrite), 32'h0);
        tick();
        chk("bb_renable", bus(), {26'd0, 6'b00_1_010});
        tick();
        chk("bb_rresp", bus(), {26'd0, 6'b10_0_000});
        chk("bb_rhrdata", hrdata, 32'h0BAD_F00D);
        tick();

        // reset during ENABLE of a write
        addr_phase(32'h0000_2008, 1'b1);
        tick();
        idle_bus();
        hwdata = 32'h5555_AAAA;
        tick();
        tick();
        chk("rs_enable", bus(), {26'd0, 6'b00_1_100});
        rst_n = 1'b0;
        tick();
        chk("rs_bus", bus(), {26'd0, 6'b10_0_000});
        chk("rs_paddr", paddr, 32'h0);
        chk("rs_hrdata", hrdata, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("rs_idle", bus(), {26'd0, 6'b10_0_000});

        // post-reset read proves FSM restarted from IDLE
        addr_phase(32'h0000_1000, 1'b0);
        prdata = 32'h7777_0000;
        tick();
        idle_bus();
        chk("pr_setup", bus(), {26'd0, 6'b00_0_010});
        tick();
        tick();
        chk("pr_hrdata", hrdata, 32'h7777_0000);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ahb2apb_bridge_ctrl.md
Name: ahb2apb_bridge_ctrl

Overview:
AHB-Lite slave to APB master bridge controller. It accepts single AHB transfers, decodes the target into a one-hot PSEL over three APB slaves, and runs the APB SETUP/ENABLE sequence. It returns read data and OKAY/ERROR responses to AHB. It is the stage directly upstream of the APB bus and drives PADDR/PWDATA/PSEL/PWRITE/PENABLE, which the APB monitor samples.

Parameters:
ADDR_W, 32, AHB/APB address width
DATA_W, 32, AHB/APB data width
NUM_SLV, 3, number of APB slaves (PSEL width)
SEL_LSB, 12, LSB of 2-bit slave-index field HADDR[SEL_LSB+1:SEL_LSB]

Ports:
HCLK  in  1  clock
HRESETn  in  1  synchronous active-low reset
HSEL  in  1  bridge selected on AHB
HADDR  in  ADDR_W  AHB address
HTRANS  in  2  AHB transfer type
HWRITE  in  1  AHB direction, 1 = write
HWDATA  in  DATA_W  AHB write data (data phase)
HREADYin  in  1  AHB bus ready
HREADYout  out  1  bridge ready / data-phase complete
HRESP  out  1  0 = OKAY, 1 = ERROR
HRDATA  out  DATA_W  read data to AHB
PADDR  out  ADDR_W  APB address
PWDATA  out  DATA_W  APB write data
PRDATA  in  DATA_W  APB read data
PSEL  out  NUM_SLV  one-hot APB slave select
PWRITE  out  1  APB direction
PENABLE  out  1  APB enable
PSLVERR  in  1  APB slave error

Behaviour:
- Reset is synchronous on HRESETn=0 at posedge HCLK. Clock and reset are single-domain. Reset values: state IDLE, HREADYout=1, HRESP=0, HRDATA=0, PADDR=0, PWDATA=0, PSEL=0, PWRITE=0, PENABLE=0. Reset mid-transfer aborts immediately with no completion.
- Valid transfer: HSEL & HREADYin & HTRANS[1] (NONSEQ/SEQ). IDLE/BUSY produce an OKAY zero-wait response.
- Decode: idx = HADDR[SEL_LSB+1:SEL_LSB]. Values 0/1/2 give PSEL 001/010/100. Value 3 is unmapped.
- A valid transfer is accepted in IDLE, RESP or ERR2. On acceptance, HADDR/HWRITE/PSEL are latched into registers.
- All outputs are registered.
- States:
  - IDLE: HREADYout=1, HRESP=0.
  - WDATA: write only. HREADYout=0. Latches HWDATA into PWDATA. Next state is SETUP.
  - SETUP: PSEL=latched, PENABLE=0, PADDR/PWRITE valid, HREADYout=0. Next state is ENABLE.
  - ENABLE: PENABLE=1, HREADYout=0. Registers PRDATA into HRDATA (reads) and samples PSLVERR. Next state is ERR1 if PSLVERR=1, else RESP.
  - RESP: PSEL=0, PENABLE=0, HREADYout=1, HRESP=0. Next state is a new accept, else IDLE.
  - ERR1: HREADYout=0, HRESP=1, APB idle. Next state is ERR2.
  - ERR2: HREADYout=1, HRESP=1. Next state is a new accept, else IDLE.
- Accept transitions: a read goes to SETUP, a write to WDATA, an unmapped address to ERR1 with no APB activity.
- Latency (data-phase cycles): read 3 (SETUP, ENABLE, RESP); write 4; unmapped 2; PSLVERR error: read 4, write 5.
- PADDR, PWRITE, PSEL and PWDATA are held stable from SETUP through ENABLE. PSEL is never multi-hot.
- A new transfer whose address phase coincides with RESP or ERR2 is accepted back-to-back. An intervening IDLE cycle is not required.
- If HTRANS=IDLE during ERR1 (master cancel), the bridge still completes ERR2.
- HRDATA holds its last value outside reads. Writes leave HRDATA unchanged.

Optional Feature:
- Macro: AHB2APB_SLVERR_EN.
- Defined: PSLVERR in ENABLE produces the two-cycle ERROR response (ERR1/ERR2).
- Undefined: PSLVERR is ignored; ENABLE always goes to RESP with OKAY. Unmapped addresses still return ERROR.

Decomposition:
- Package ahb_apb_pkg:
  - htrans_e (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11)
  - bridge_state_e (IDLE, WDATA, SETUP, ENABLE, RESP, ERR1, ERR2)
  - HRESP_OKAY / HRESP_ERROR constants
  - default SEL_LSB and NUM_SLV
- Sub-module apb_addr_decoder: combinational HADDR to one-hot PSEL plus an unmapped flag.

Test Plan:
- Read from HADDR=0x0000_1004, PRDATA=0xDEAD_BEEF -> PSEL=010 for one SETUP cycle then one ENABLE cycle; HRDATA=0xDEAD_BEEF, HRESP=0, HREADYout high 3 cycles after the address phase.
- Write HADDR=0x0000_2008, HWDATA=0x1234_5678 -> PSEL=100, PWRITE=1, PWDATA=0x1234_5678 stable over SETUP and ENABLE; HREADYout high after 4 cycles.
- Access HADDR=0x0000_3000 -> PSEL stays 000, PENABLE stays 0; HRESP=1 for 2 cycles, with HREADYout 0 then 1.
- Read to 0x0000_0000 with PSLVERR=1 in ENABLE -> with AHB2APB_SLVERR_EN: ERR1 then ERR2 (HRESP=1); without it: RESP with HRESP=0.
- Back-to-back write to 0x0000_0010 then read from 0x0000_1010, second address phase issued during the RESP cycle -> second SETUP follows WDATA-free, with no IDLE gap; PSEL goes 001 then 010.
- Assert HRESETn=0 during ENABLE of a write -> next cycle PSEL=0, PENABLE=0, HREADYout=1, HRESP=0, state IDLE.
